// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/subtract: WIDTH bits, DIGIT bits per clock, LSB digit first.
// Latency: done is asserted WIDTH/DIGIT edges after the accept edge (N+1 edges counting the accept edge itself).
// Backpressure: none queued; start is ignored while busy, so the caller must wait for busy to fall.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 last;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     work;
    logic [WIDTH-1:0]     work_nxt;
    logic [WIDTH+DIGIT-1:0] shift_cat;
    logic [CW-1:0]        cnt;
    logic                 carry;
    logic [DIGIT:0]       dsum;
    logic                 msb_cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                last = (cnt == CW'(N - 1));
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One digit of the ripple: the carry register links consecutive cycles.
    always_comb begin
        dsum      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(carry);
        shift_cat = {dsum[DIGIT-1:0], work};
        work_nxt  = shift_cat[WIDTH+DIGIT-1:DIGIT];
        // Carry into the result MSB, recovered from the top bit of the final digit.
        msb_cin   = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= c_in ^ sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                work  <= work_nxt;
                carry <= dsum[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum   <= work_nxt;
                    c_out <= dsum[DIGIT];
                    ovf   <= msb_cin ^ dsum[DIGIT];
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboarded bench: directed vectors on a 16/4 instance plus random sweeps on 16/1, 16/16 and 8/2 instances.
module tb_serial_addsub;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        int          edge_n;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [2:0]  sweep_fin;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- directed instance, WIDTH=16 DIGIT=4 ----------------
    logic        reset, start, sub, c_in;
    logic [15:0] a, b;
    logic        busy, done, c_out, ovf;
    logic [15:0] sum;
    exp_t        q[$];

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 64'(sum), e.s);
                chk("c_out", 64'(c_out), 64'(e.co));
                chk("ovf", 64'(ovf), 64'(e.ov));
                chk("done latency", 64'(cyc), 64'(e.edge_n));
            end
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tsub,
                         input logic tcin, input logic [15:0] es, input logic eco, input logic eov);
        exp_t e;
        int   n;
        a = ta; b = tb_; sub = tsub; c_in = tcin; start = 1'b1;
        e.s = 64'(es); e.co = eco; e.ov = eov; e.edge_n = cyc + 1 + 4;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy cycles", 64'(n), 64'd4);
    endtask

    initial begin
        int n;
        exp_t e;
        reset = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sum", 64'(sum), 64'd0);
        chk("reset c_out", 64'(c_out), 64'd0);
        chk("reset ovf", 64'(ovf), 64'd0);

        issue(16'd3,    16'd4,    1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        @(negedge clk);
        chk("done one cycle", 64'(done), 64'd0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'd5,    16'd7,    1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        issue(16'd5,    16'd2,    1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        issue(16'd1,    16'd1,    1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);

        // start re-pulsed while running must be ignored; sum holds the previous result
        a = 16'h1234; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        e.s = 64'h2345; e.co = 1'b0; e.ov = 1'b0; e.edge_n = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
        @(negedge clk);
        chk("sum held during run", 64'(sum), 64'h0003);
        @(negedge clk);
        start = 1'b0;
        chk("sum held late run", 64'(sum), 64'h0003);
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        chk("busy cycles re-pulse", 64'(n), 64'd2);
        @(negedge clk);
        chk("no queued op", 64'(busy), 64'd0);

        // reset on the 2nd RUN cycle aborts without a done pulse
        a = 16'd9; b = 16'd9; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort sum", 64'(sum), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        repeat (6) @(negedge clk);

        // start held high: one result every 5 cycles
        a = 16'h0100; b = 16'h0011; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e.s = 64'h0111; e.co = 1'b0; e.ov = 1'b0; e.edge_n = cyc + 5 + 5 * k;
            q.push_back(e);
        end
        repeat (18) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        repeat (3) @(negedge clk);
        chk("directed queue drained", 64'(q.size()), 64'd0);

        n = 0;
        while (sweep_fin != 3'b111 && n < 60000) begin n++; @(negedge clk); end
        chk("sweep finished", 64'(sweep_fin), 64'h7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // ---------------- random parameter sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 2) ? 8 : 16;
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 16 : 2);
        localparam int N = W / D;

        logic         s_reset, s_start, s_sub, s_cin;
        logic [W-1:0] s_a, s_b, s_sum;
        logic         s_busy, s_done, s_cout, s_ovf;
        exp_t         sq[$];

        serial_addsub #(.WIDTH(W), .DIGIT(D)) dut_s (
            .clk(clk), .reset(s_reset), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
            .c_in(s_cin), .busy(s_busy), .done(s_done), .sum(s_sum), .c_out(s_cout), .ovf(s_ovf)
        );

        always @(negedge clk) begin
            if (s_done) begin
                if (sq.size() == 0) begin
                    chk("sweep unexpected done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    chk("sweep sum", 64'(s_sum), e.s);
                    chk("sweep c_out", 64'(s_cout), 64'(e.co));
                    chk("sweep ovf", 64'(s_ovf), 64'(e.ov));
                    chk("sweep latency", 64'(cyc), 64'(e.edge_n));
                end
            end
        end

        initial begin
            logic [W:0]   full;
            logic [W-1:0] bb;
            exp_t         e;
            int           n;
            sweep_fin[g] = 1'b0;
            s_reset = 1'b1; s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
            repeat (3) @(negedge clk);
            s_reset = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                s_a   = W'($urandom);
                s_b   = W'($urandom);
                s_sub = 1'($urandom_range(0, 1));
                s_cin = 1'($urandom_range(0, 1));
                bb    = s_sub ? ~s_b : s_b;
                full  = {1'b0, s_a} + {1'b0, bb} + (W+1)'(s_cin ^ s_sub);
                e.s   = 64'(full[W-1:0]);
                e.co  = full[W];
                e.ov  = (s_a[W-1] == bb[W-1]) && (full[W-1] != s_a[W-1]);
                e.edge_n = cyc + 1 + N;
                sq.push_back(e);
                s_start = 1'b1;
                @(negedge clk);
                s_start = 1'b0;
                n = 0;
                while (s_busy && n < 100) begin n++; @(negedge clk); end
                if (n >= 100) chk("sweep busy timeout", 64'(n), 64'(N));
            end
            repeat (2) @(negedge clk);
            chk("sweep queue drained", 64'(sq.size()), 64'd0);
            sweep_fin[g] = 1'b1;
        end
    end

endmodule
